// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the sequential restoring divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 4;

  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract
module divider_step #(
  parameter int W = 8
) (
  input  logic [W:0]   r_i,
  input  logic         bit_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   r_o,
  output logic         q_o
);

  // r_i never exceeds b_i-1, so its top bit is zero; keeping it in t avoids a dangling bit.
  logic [W+1:0] t;

  always_comb begin
    t   = {r_i, bit_i};
    q_o = (t >= {2'b00, b_i});
    r_o = q_o ? (W+1)'(t - {2'b00, b_i}) : t[W:0];
  end

endmodule

// File: rtl/eight_bit_sequential_divider.sv
// rtl/eight_bit_sequential_divider.sv - iterative divider: FSM, shift registers and result registers
module eight_bit_sequential_divider #(
  parameter int DIVIDEND_W = divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend_in,
  input  logic [DIVISOR_W-1:0]  divisor_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  import divider_pkg::*;

  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic [DIVIDEND_W-1:0] a_q, a_d;
  logic [DIVISOR_W-1:0]  b_q, b_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dz_pend_q, dz_pend_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    r_next;
  logic                  q_bit;
  logic                  accept;

  divider_step #(.W(DIVISOR_W)) u_step (
    .r_i   (r_q),
    .bit_i (a_q[DIVIDEND_W-1]),
    .b_i   (b_q),
    .r_o   (r_next),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    dz_pend_d   = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero divisor spends one idle cycle here so done lands one edge after the start.
        if (dz_pend_q) begin
          state_d     = FINISH;
          quotient_d  = DIVIDEND_W'(DIV0_QUOTIENT);
          remainder_d = a_q[DIVISOR_W-1:0];
          dbz_d       = 1'b1;
        end else begin
          accept = start;
        end
      end
      RUN: begin
        a_d   = a_q << 1;
        r_d   = r_next;
        q_d   = {q_q[DIVIDEND_W-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = FINISH;
          quotient_d  = {q_q[DIVIDEND_W-2:0], q_bit};
          remainder_d = r_next[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
        end
      end
      FINISH: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d   = dividend_in;
      b_d   = divisor_in;
      r_d   = '0;
      q_d   = '0;
      cnt_d = '0;
      if (divisor_in == '0) begin
        state_d   = IDLE;
        dz_pend_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      dz_pend_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      dz_pend_q   <= dz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FINISH);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_eight_bit_sequential_divider.sv
// tb/tb_eight_bit_sequential_divider.sv - directed and randomized checks of the sequential divider
module tb_eight_bit_sequential_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend_in;
  logic [7:0]  divisor_in;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  eight_bit_sequential_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    dividend_in = dd;
    divisor_in  = dv;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // lat counts edges since the accepting edge; optionally pokes start at poke_lat.
  task automatic wait_done(input int poke_lat, output int lat, output bit busy_seen,
                           output bit overlap);
    lat       = 0;
    busy_seen = 1'b0;
    overlap   = 1'b0;
    while (!done && lat < 40) begin
      if (busy) busy_seen = 1'b1;
      if (lat == poke_lat) begin
        dividend_in = 16'h0001;
        divisor_in  = 8'h01;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input int poke_lat);
    int lat;
    bit bsy;
    bit ovl;
    start_op(dd, dv);
    wait_done(poke_lat, lat, bsy, ovl);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, edz);
    check({tag, "_busy"}, bsy, !edz);
    check({tag, "_ovl"}, ovl, 1'b0);
  endtask

  initial begin
    int lat;
    int dcount;
    bit bsy;
    bit ovl;
    logic [15:0] rdd;
    logic [7:0]  rdv;
    logic [7:0]  ma;
    logic [7:0]  mb;

    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 16'h0000);
    check("rst_r", remainder, 8'h00);
    check("rst_dz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("inv_mul", 16'h6018, 8'h7B, 16'h00C8, 8'h00, 1'b0, 16, -1);
    run_div("max_1",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16, -1);
    run_div("max_ff",  16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16, -1);
    run_div("zero_dd", 16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 16, -1);

    // Back-to-back: start held in FINISH, no idle gap.
    run_div("rem_7",   16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16, -1);
    run_div("b2b_10",  16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16, -1);
    @(negedge clk);

    run_div("div0",    16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1, -1);
    @(negedge clk);
    run_div("clr_dz",  16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16, -1);
    @(negedge clk);

    // Start pulsed mid-operation must not disturb the operands in flight.
    run_div("poke",    16'h6018, 8'h7B, 16'h00C8, 8'h00, 1'b0, 16, 5);
    @(negedge clk);
    check("poke_idle", busy | done, 1'b0);

    // Reset at iteration 9 aborts without done.
    start_op(16'h03E8, 8'h07);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", quotient, 16'h0000);
    check("mid_rst_r", remainder, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_dz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("post_rst_quiet", dcount, 0);
    run_div("post_rst", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16, -1);
    @(negedge clk);

    // Random pairs against a / and % reference; zero divisors included.
    for (int i = 0; i < 200; i++) begin
      rdd = 16'($urandom);
      rdv = (i % 25 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      start_op(rdd, rdv);
      wait_done(-1, lat, bsy, ovl);
      if (rdv == 8'h00) begin
        check("rnd_q", quotient, 16'hFFFF);
        check("rnd_r", remainder, {24'h0, rdd[7:0]});
        check("rnd_dz", div_by_zero, 1'b1);
        check("rnd_lat", lat, 1);
      end else begin
        check("rnd_q", quotient, rdd / rdv);
        check("rnd_r", remainder, rdd % rdv);
        check("rnd_dz", div_by_zero, 1'b0);
        check("rnd_lat", lat, 16);
      end
      @(negedge clk);
    end

    // Multiplier products must divide back to the other operand exactly.
    for (int i = 0; i < 60; i++) begin
      ma = 8'($urandom_range(0, 255));
      mb = 8'($urandom_range(1, 255));
      start_op(16'(ma * mb), mb);
      wait_done(-1, lat, bsy, ovl);
      check("mul_q", quotient, {8'h00, ma});
      check("mul_r", remainder, 8'h00);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
